// File: rtl/receptor_serie_paralelo_pkg.sv
// Shared framing constants and FSM encodings for the serial-to-parallel sensor receiver.
// The sync window helper is the single definition of what a valid frame boundary looks like.
package receptor_serie_paralelo_pkg;

  localparam int FRAME_LEN   = 16;
  localparam int PAYLOAD_LSB = 3;
  localparam int PAYLOAD_MSB = 9;

  localparam logic [15:0] SYNC_PATTERN = 16'hF803;
  localparam logic [15:0] SYNC_MASK    = 16'hFC07;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  function automatic logic is_sync(input logic [15:0] w);
    return (w & SYNC_MASK) == SYNC_PATTERN;
  endfunction

endpackage

// File: rtl/receptor_serie_paralelo_contador.sv
// Mod-16 bit position counter within a frame; fin flags the last bit of the frame.
module contador_trama
  import receptor_serie_paralelo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       fin
);

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= 4'd0;
    else              cnt <= cnt + 4'd1;
  end

  assign fin = (cnt == 4'(FRAME_LEN - 1));

endmodule

// File: rtl/receptor_serie_paralelo.sv
// Frame aligner for the 7-sensor serial stream: hunts for the sync window, confirms it over
// consecutive frames, then presents each good frame's payload in parallel.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HUNT    | searching every clk for a sync window
// ST_CONFIRM | candidate alignment found, checking following boundaries
// ST_LOCKED  | aligned; payload published, consecutive bad frames counted
module receptor_serie_paralelo
  import receptor_serie_paralelo_pkg::*;
#(
  parameter int CONFIRM_FRAMES = 2,
  parameter int MAX_ERRORS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [6:0] datos,
  output logic       trama_valida,
  output logic       error_trama,
  output logic       enganchado
);

  localparam logic [2:0] CONF_TGT = 3'(CONFIRM_FRAMES);
  localparam logic [2:0] ERR_TGT  = 3'(MAX_ERRORS);

  logic [15:0] sr, sr_next;
  logic        match;
  logic [1:0]  state;
  logic [2:0]  conf, err;
  logic [3:0]  bit_cnt;
  logic        fin;
  logic        unused_bits;

  assign sr_next = {din, sr[15:1]};
  assign match   = is_sync(sr_next);

  // bit_cnt only matters through fin; sr[0] is consumed via sr_next before it is shifted out
  assign unused_bits = ^{bit_cnt, sr[0]};

  // Held at zero while hunting so the first boundary check lands 16 shifts after the match
  contador_trama u_contador (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_HUNT),
    .cnt   (bit_cnt),
    .fin   (fin)
  );

  assign enganchado = (state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr           <= 16'd0;
      state        <= ST_HUNT;
      conf         <= 3'd0;
      err          <= 3'd0;
      datos        <= 7'd0;
      trama_valida <= 1'b0;
      error_trama  <= 1'b0;
    end else begin
      sr           <= sr_next;
      trama_valida <= 1'b0;
      error_trama  <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (match) begin
            datos <= sr_next[PAYLOAD_MSB:PAYLOAD_LSB];
            conf  <= 3'd1;
            err   <= 3'd0;
            state <= (CONF_TGT == 3'd1) ? ST_LOCKED : ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (fin) begin
            if (match) begin
              conf <= conf + 3'd1;
              if (conf + 3'd1 == CONF_TGT) begin
                state        <= ST_LOCKED;
                datos        <= sr_next[PAYLOAD_MSB:PAYLOAD_LSB];
                trama_valida <= 1'b1;
              end
            end else begin
              state <= ST_HUNT;
              conf  <= 3'd0;
            end
          end
        end
        ST_LOCKED: begin
          if (fin) begin
            if (match) begin
              datos        <= sr_next[PAYLOAD_MSB:PAYLOAD_LSB];
              trama_valida <= 1'b1;
              err          <= 3'd0;
            end else begin
              error_trama <= 1'b1;
              if (err + 3'd1 == ERR_TGT) begin
                state <= ST_HUNT;
                err   <= 3'd0;
                conf  <= 3'd0;
              end else begin
                err <= err + 3'd1;
              end
            end
          end
        end
        default: begin
          state <= ST_HUNT;
          conf  <= 3'd0;
          err   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receptor_serie_paralelo.sv
// Scoreboard bench for receptor_serie_paralelo: directed frame streams, expected pulses queued
// by the stimulus and popped by an independent negedge monitor.
module tb_receptor_serie_paralelo;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic [6:0] datos;
  logic       trama_valida, error_trama, enganchado;

  receptor_serie_paralelo #(.CONFIRM_FRAMES(2), .MAX_ERRORS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .datos        (datos),
    .trama_valida (trama_valida),
    .error_trama  (error_trama),
    .enganchado   (enganchado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [6:0] data;
    logic       lock;
  } exp_t;

  localparam int K_NONE = 0, K_VALID = 1, K_ERR = 2;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       tolerant = 1'b0;
  logic [6:0] tol_data = 7'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every pulse must be explained by a queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (trama_valida === 1'b1 || error_trama === 1'b1) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse trama_valida", 32'(trama_valida), 32'(!e.is_err));
        check("pulse error_trama", 32'(error_trama), 32'(e.is_err));
        check("pulse datos", 32'(datos), 32'(e.data));
        check("pulse enganchado", 32'(enganchado), 32'(e.lock));
      end else if (tolerant && trama_valida === 1'b1 && error_trama === 1'b0) begin
        check("acquisition datos", 32'(datos), 32'(tol_data));
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected pulse: actual tv=%b err=%b datos=%h, required no pulse",
                 trama_valida, error_trama, datos);
      end
    end
  end

  // Frame bits from the wire format: b0=1 b1=1 b2=0 b3..b9=data b10=0 b11..b15=1
  function automatic logic [15:0] mk_frame(input logic [6:0] d, input logic bad);
    return {5'b11111, bad, d, 3'b011};
  endfunction

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] f, input int from, input int upto);
    for (int i = from; i <= upto; i++) send_bit(f[i]);
  endtask

  task automatic push(input logic is_err, input logic [6:0] d, input logic l);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    e.lock   = l;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic bad, input int kind,
                            input logic [6:0] ed, input logic el);
    logic [15:0] f;
    f = mk_frame(d, bad);
    send_bits(f, 0, 14);
    if (kind != K_NONE) push(kind == K_ERR, ed, el);
    send_bit(f[15]);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check({tag, " reset datos"}, 32'(datos), 32'h0);
    check({tag, " reset trama_valida"}, 32'(trama_valida), 32'h0);
    check({tag, " reset error_trama"}, 32'(error_trama), 32'h0);
    check({tag, " reset enganchado"}, 32'(enganchado), 32'h0);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    #1;
    check({tag, " expected pulses outstanding"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f;
    reset = 1'b1;
    din   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("T0");

    // T1: aligned stream, lock exactly 16 clk after the first aligned b15
    send_frame(7'h55, 1'b0, K_NONE, 7'h00, 1'b0);
    check("T1 enganchado after 1st frame", 32'(enganchado), 32'h0);
    f = mk_frame(7'h55, 1'b0);
    send_bits(f, 0, 14);
    check("T1 enganchado 15 clk after match", 32'(enganchado), 32'h0);
    push(1'b0, 7'h55, 1'b1);
    send_bit(f[15]);
    check("T1 enganchado 16 clk after match", 32'(enganchado), 32'h1);
    check("T1 datos at lock", 32'(datos), 32'h55);
    for (int i = 0; i < 2; i++) send_frame(7'h55, 1'b0, K_VALID, 7'h55, 1'b1);
    drain("T1");

    // T4: two bad frames keep lock and hold datos; a good frame clears the error count
    for (int i = 0; i < 2; i++) send_frame(7'h11, 1'b1, K_ERR, 7'h55, 1'b1);
    check("T4 still enganchado", 32'(enganchado), 32'h1);
    check("T4 datos held", 32'(datos), 32'h55);
    send_frame(7'h55, 1'b0, K_VALID, 7'h55, 1'b1);
    drain("T4");

    // T5: three bad frames drop lock on the third boundary, then relock
    send_frame(7'h55, 1'b1, K_ERR, 7'h55, 1'b1);
    send_frame(7'h55, 1'b1, K_ERR, 7'h55, 1'b1);
    send_frame(7'h55, 1'b1, K_ERR, 7'h55, 1'b0);
    check("T5 enganchado after 3rd bad", 32'(enganchado), 32'h0);
    send_frame(7'h55, 1'b0, K_NONE, 7'h00, 1'b0);
    check("T5 enganchado during confirm", 32'(enganchado), 32'h0);
    send_frame(7'h55, 1'b0, K_VALID, 7'h55, 1'b1);
    check("T5 relocked", 32'(enganchado), 32'h1);
    drain("T5");

    // T6: locked on 0x2A, reset mid-frame, relock
    for (int i = 0; i < 2; i++) send_frame(7'h2A, 1'b0, K_VALID, 7'h2A, 1'b1);
    drain("T6 pre");
    f = mk_frame(7'h2A, 1'b0);
    send_bits(f, 0, 7);
    do_reset("T6");
    send_frame(7'h2A, 1'b0, K_NONE, 7'h00, 1'b0);
    check("T6 enganchado after 1st frame", 32'(enganchado), 32'h0);
    send_frame(7'h2A, 1'b0, K_VALID, 7'h2A, 1'b1);
    check("T6 relocked", 32'(enganchado), 32'h1);
    check("T6 datos", 32'(datos), 32'h2A);
    drain("T6");

    // T2: stream entered at bit 7; lock within 2 frames + 15 clk
    do_reset("T2");
    f = mk_frame(7'h33, 1'b0);
    send_bits(f, 7, 15);
    send_frame(7'h33, 1'b0, K_NONE, 7'h00, 1'b0);
    check("T2 enganchado before confirm", 32'(enganchado), 32'h0);
    send_frame(7'h33, 1'b0, K_VALID, 7'h33, 1'b1);
    check("T2 locked in bound", 32'(enganchado), 32'h1);
    check("T2 datos", 32'(datos), 32'h33);
    drain("T2");

    // T3: all-ones payload entered mid-frame; whichever alignment wins must present 0x7F
    do_reset("T3");
    tolerant = 1'b1;
    tol_data = 7'h7F;
    f = mk_frame(7'h7F, 1'b0);
    send_bits(f, 5, 15);
    for (int i = 0; i < 4; i++) begin
      send_frame(7'h7F, 1'b0, K_NONE, 7'h00, 1'b0);
      if (enganchado === 1'b1) break;
    end
    check("T3 locked in bound", 32'(enganchado), 32'h1);
    check("T3 datos", 32'(datos), 32'h7F);
    drain("T3");
    tolerant = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
